// File: rtl/fetch_mem_arbiter.sv
// Round-robin arbiter sharing one memory read port between instruction fetch and load/store,
// with a watchdog that completes stalled reads with a per-requester fill value.
module fetch_mem_arbiter #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                TIMEOUT  = 255,
   parameter logic [DATA_W-1:0] IFU_FILL = DATA_W'(32'h0000_0013),
   parameter logic [DATA_W-1:0] LSU_FILL = DATA_W'(32'h0000_0000)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_resp_valid,
   output logic [DATA_W-1:0] ifu_rdata,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_addr,
   output logic              lsu_resp_valid,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              timeout_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t            state_r;
   logic              last_lsu_r;
   logic              owner_lsu_r;
   logic [ADDR_W-1:0] addr_r;
   logic [15:0]       cnt_r;
   logic              grant_ifu_s;
   logic              grant_lsu_s;

   // Grant decision: a lone requester wins; on contention the one not served last wins.
   always_comb begin
      grant_ifu_s = 1'b0;
      grant_lsu_s = 1'b0;
      if (state_r == ST_IDLE) begin
         if (ifu_req_valid && lsu_req_valid) begin
            if (last_lsu_r) begin
               grant_ifu_s = 1'b1;
            end else begin
               grant_lsu_s = 1'b1;
            end
         end else if (ifu_req_valid) begin
            grant_ifu_s = 1'b1;
         end else if (lsu_req_valid) begin
            grant_lsu_s = 1'b1;
         end else begin
            grant_ifu_s = 1'b0;
            grant_lsu_s = 1'b0;
         end
      end else begin
         grant_ifu_s = 1'b0;
         grant_lsu_s = 1'b0;
      end
   end

   assign ifu_req_ready = grant_ifu_s;
   assign lsu_req_ready = grant_lsu_s;
   assign mem_req_valid = (state_r == ST_REQ);
   assign mem_addr      = addr_r;

   // Transaction FSM, watchdog counter and registered response routing.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r        <= ST_IDLE;
         last_lsu_r     <= 1'b1;
         owner_lsu_r    <= 1'b0;
         addr_r         <= '0;
         cnt_r          <= 16'd0;
         ifu_resp_valid <= 1'b0;
         lsu_resp_valid <= 1'b0;
         timeout_err    <= 1'b0;
         ifu_rdata      <= IFU_FILL;
         lsu_rdata      <= '0;
      end else begin
         ifu_resp_valid <= 1'b0;
         lsu_resp_valid <= 1'b0;
         timeout_err    <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (grant_ifu_s || grant_lsu_s) begin
                  addr_r      <= grant_lsu_s ? lsu_addr : ifu_addr;
                  owner_lsu_r <= grant_lsu_s;
                  last_lsu_r  <= grant_lsu_s;
                  state_r     <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (mem_req_ready) begin
                  cnt_r   <= 16'd0;
                  state_r <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // A real response on the expiry cycle takes priority over the watchdog.
               if (mem_resp_valid) begin
                  if (owner_lsu_r) begin
                     lsu_resp_valid <= 1'b1;
                     lsu_rdata      <= mem_rdata;
                  end else begin
                     ifu_resp_valid <= 1'b1;
                     ifu_rdata      <= mem_rdata;
                  end
                  state_r <= ST_IDLE;
               end else if (cnt_r == TO_LAST) begin
                  if (owner_lsu_r) begin
                     lsu_resp_valid <= 1'b1;
                     lsu_rdata      <= LSU_FILL;
                  end else begin
                     ifu_resp_valid <= 1'b1;
                     ifu_rdata      <= IFU_FILL;
                  end
                  timeout_err <= 1'b1;
                  state_r     <= ST_IDLE;
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

endmodule
